hwpe_stream_split_scheduler: RTL and testbench

HWPE_STREAM_SPLIT_SCHEDULER -- requirements
Module: hwpe_stream_split_scheduler

---
 rtl/hwpe_stream_split_scheduler.sv | 105 ++++++++++
 tb/tb_hwpe_stream_split_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_split_scheduler.sv
// Splits one wide input beat across NB_OUT_STREAMS narrow lanes and lets each lane take
// its slice independently; the input beat retires only after every enabled lane has it.
module hwpe_stream_split_scheduler #(
   parameter int unsigned NB_OUT_STREAMS = 2,
   parameter int unsigned DATA_WIDTH_IN  = 128,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   input  logic [DATA_WIDTH_IN-1:0]    push_data_i,
   input  logic [DATA_WIDTH_IN/8-1:0]  push_strb_i,
   input  logic                        push_valid_i,
   output logic                        push_ready_o,
   output logic [DATA_WIDTH_IN-1:0]    pop_data_o,
   output logic [DATA_WIDTH_IN/8-1:0]  pop_strb_o,
   output logic [NB_OUT_STREAMS-1:0]   pop_valid_o,
   input  logic [NB_OUT_STREAMS-1:0]   pop_ready_i,
   input  logic [NB_OUT_STREAMS-1:0]   lane_en_i,
   output logic [CNT_WIDTH-1:0]        beat_cnt_o,
   output logic                        busy_o
);

   localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN / NB_OUT_STREAMS;
   localparam int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / 8;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t                    state_q, state_d;
   logic [NB_OUT_STREAMS-1:0] mask_q, mask_d;
   logic [NB_OUT_STREAMS-1:0] served_q, served_d;
   logic [CNT_WIDTH-1:0]      beat_cnt_q, beat_cnt_d;

   logic [NB_OUT_STREAMS-1:0] eff;
   logic [NB_OUT_STREAMS-1:0] hs;
   logic                      done;
   logic                      push_hs;

   // Lanes are sliced positionally, so the data path is a plain wire.
   assign pop_data_o = push_data_i;
   assign pop_strb_o = push_strb_i;

   // The lane mask is frozen once a beat goes partial, so late lane_en_i edits wait a beat.
   assign eff         = (state_q == ACTIVE) ? mask_q : lane_en_i;
   assign pop_valid_o = {NB_OUT_STREAMS{push_valid_i & ~clear_i & ~rst_i}} & eff & ~served_q;
   assign hs          = pop_valid_o & pop_ready_i;
   assign done        = &(~eff | served_q | hs);
   assign push_hs     = push_valid_i & done & ~clear_i & ~rst_i;

   assign push_ready_o = push_hs;
   assign beat_cnt_o   = beat_cnt_q;
   assign busy_o       = (state_q == ACTIVE);

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      served_d   = served_q;
      beat_cnt_d = beat_cnt_q + (push_hs ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
      if (clear_i) begin
         state_d    = IDLE;
         mask_d     = '0;
         served_d   = '0;
         beat_cnt_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (push_valid_i && !done) begin
                  state_d  = ACTIVE;
                  mask_d   = lane_en_i;
                  served_d = hs;
               end
            end
            ACTIVE: begin
               if (done) begin
                  state_d  = IDLE;
                  served_d = '0;
               end else begin
                  served_d = served_q | hs;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         served_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         served_q   <= served_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // A partially delivered beat must be held by the producer until every lane has it.
   a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == ACTIVE && !clear_i) |-> push_valid_i)
      else $error("push_valid_i dropped while a beat was partially delivered");

endmodule

// File: tb/tb_hwpe_stream_split_scheduler.sv
// Directed bench for the split scheduler: 4 lanes, 4-bit beat counter.
module tb_hwpe_stream_split_scheduler;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 128;
   localparam int unsigned CW  = 4;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b0;
   logic            clear_i = 1'b0;
   logic [DW-1:0]   push_data_i = '0;
   logic [DW/8-1:0] push_strb_i = '0;
   logic            push_valid_i = 1'b0;
   logic            push_ready_o;
   logic [DW-1:0]   pop_data_o;
   logic [DW/8-1:0] pop_strb_o;
   logic [N-1:0]    pop_valid_o;
   logic [N-1:0]    pop_ready_i = '0;
   logic [N-1:0]    lane_en_i = '0;
   logic [CW-1:0]   beat_cnt_o;
   logic            busy_o;

   int checks = 0;
   int failures = 0;

   hwpe_stream_split_scheduler #(
      .NB_OUT_STREAMS(N),
      .DATA_WIDTH_IN (DW),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .push_data_i (push_data_i),
      .push_strb_i (push_strb_i),
      .push_valid_i(push_valid_i),
      .push_ready_o(push_ready_o),
      .pop_data_o  (pop_data_o),
      .pop_strb_o  (pop_strb_o),
      .pop_valid_o (pop_valid_o),
      .pop_ready_i (pop_ready_i),
      .lane_en_i   (lane_en_i),
      .beat_cnt_o  (beat_cnt_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #1 rst_i = 1'b1;
      push_valid_i = 1'b1;
      lane_en_i    = 4'hF;
      pop_ready_i  = 4'hF;
      #1;
      chk("rst_push_ready", 32'(push_ready_o), 32'd0);
      chk("rst_pop_valid",  32'(pop_valid_o),  32'd0);
      chk("rst_busy",       32'(busy_o),       32'd0);
      chk("rst_cnt",        32'(beat_cnt_o),   32'd0);
      tick();
      tick();
      rst_i = 1'b0;
      push_data_i = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      push_strb_i = 16'hF0A5;
      #1;
      chk("pass_data_lane3", pop_data_o[127:96], 32'hDDDD_0003);
      chk("pass_data_lane0", pop_data_o[31:0],   32'hAAAA_0000);
      chk("pass_strb",       32'(pop_strb_o),    32'h0000_F0A5);

      // Three back-to-back single-cycle beats.
      for (int i = 0; i < 3; i++) begin
         chk("full_pop_valid",  32'(pop_valid_o),  32'hF);
         chk("full_push_ready", 32'(push_ready_o), 32'd1);
         chk("full_busy",       32'(busy_o),       32'd0);
         tick();
      end
      chk("full_cnt", 32'(beat_cnt_o), 32'd3);
      push_valid_i = 1'b0;
      tick();

      // Split delivery over two cycles.
      push_valid_i = 1'b1;
      pop_ready_i  = 4'b0101;
      #1;
      chk("split_c0_pop_valid",  32'(pop_valid_o),  32'hF);
      chk("split_c0_push_ready", 32'(push_ready_o), 32'd0);
      tick();
      chk("split_c1_busy",       32'(busy_o),       32'd1);
      chk("split_c1_pop_valid",  32'(pop_valid_o),  32'b1010);
      pop_ready_i = 4'b1010;
      #1;
      chk("split_c1_push_ready", 32'(push_ready_o), 32'd1);
      tick();
      chk("split_busy_after", 32'(busy_o),     32'd0);
      chk("split_cnt",        32'(beat_cnt_o), 32'd4);

      // Mask frozen in ACTIVE despite lane_en_i change.
      pop_ready_i = 4'h0;
      tick();
      chk("mask_busy", 32'(busy_o), 32'd1);
      lane_en_i   = 4'h1;
      pop_ready_i = 4'hF;
      #1;
      chk("mask_frozen_pop_valid", 32'(pop_valid_o),  32'hF);
      chk("mask_frozen_ready",     32'(push_ready_o), 32'd1);
      tick();
      chk("mask_cnt",            32'(beat_cnt_o),  32'd5);
      chk("mask_next_pop_valid", 32'(pop_valid_o), 32'h1);
      chk("mask_next_ready",     32'(push_ready_o), 32'd1);
      tick();
      chk("mask_next_cnt", 32'(beat_cnt_o), 32'd6);

      // No enabled lanes: beats are swallowed but counted.
      lane_en_i = 4'h0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("empty_pop_valid",  32'(pop_valid_o),  32'h0);
         chk("empty_push_ready", 32'(push_ready_o), 32'd1);
         tick();
      end
      chk("empty_cnt", 32'(beat_cnt_o), 32'd8);
      chk("empty_busy", 32'(busy_o),    32'd0);

      // Clear in ACTIVE after lane 0 is served.
      lane_en_i   = 4'hF;
      pop_ready_i = 4'b0001;
      tick();
      chk("clr_busy_before", 32'(busy_o),      32'd1);
      chk("clr_remaining",   32'(pop_valid_o), 32'b1110);
      clear_i     = 1'b1;
      pop_ready_i = 4'h0;
      #1;
      chk("clr_pop_valid",  32'(pop_valid_o),  32'h0);
      chk("clr_push_ready", 32'(push_ready_o), 32'd0);
      tick();
      clear_i = 1'b0;
      #1;
      chk("clr_busy_after", 32'(busy_o),      32'd0);
      chk("clr_cnt",        32'(beat_cnt_o),  32'd0);
      chk("clr_represent",  32'(pop_valid_o), 32'hF);
      pop_ready_i = 4'hF;
      #1;
      chk("clr_redeliver_ready", 32'(push_ready_o), 32'd1);
      tick();
      chk("clr_redeliver_cnt", 32'(beat_cnt_o), 32'd1);

      // Async reset in ACTIVE abandons the partial beat.
      pop_ready_i = 4'b0011;
      tick();
      chk("arst_busy_before", 32'(busy_o), 32'd1);
      pop_ready_i = 4'h0;
      #2 rst_i = 1'b1;
      #1;
      chk("arst_busy",       32'(busy_o),       32'd0);
      chk("arst_cnt",        32'(beat_cnt_o),   32'd0);
      chk("arst_pop_valid",  32'(pop_valid_o),  32'h0);
      chk("arst_push_ready", 32'(push_ready_o), 32'd0);
      tick();
      rst_i = 1'b0;
      #1;
      chk("arst_represent", 32'(pop_valid_o), 32'hF);
      push_valid_i = 1'b0;
      tick();

      // Counter wrap with CNT_WIDTH=4.
      pop_ready_i  = 4'hF;
      push_valid_i = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         tick();
         if (i == 15) chk("wrap_15", 32'(beat_cnt_o), 32'd15);
         if (i == 16) chk("wrap_16", 32'(beat_cnt_o), 32'd0);
         if (i == 17) chk("wrap_17", 32'(beat_cnt_o), 32'd1);
      end
      push_valid_i = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
